// File: rtl/mod_counter_unit.sv
// Run/stop, up/down modulo counter with tick prescaler and merged button/UART command decode.
// Define COUNTER_LOAD_EN to compile in decimal preload over UART ('l', digits, CR commit / ESC abort).
module mod_counter_unit #(
  parameter int CNT_MAX  = 9999,
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_clear,
  input  logic             btn_run,
  input  logic             btn_mode,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_running,
  output logic             o_mode,
  output logic             o_wrap,
  output logic             o_loading
);
  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);

  localparam logic [7:0] CH_CLR  = 8'h63;
  localparam logic [7:0] CH_RUN  = 8'h72;
  localparam logic [7:0] CH_MODE = 8'h6D;

  logic             ev_clr, ev_run, ev_mode, ev_byte, tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             commit;
  logic [CNT_W-1:0] load_val;

  // One event per cycle: anything below the winning event is dropped.
  assign ev_clr  = btn_clear | (cmd_valid & (cmd_data == CH_CLR));
  assign ev_run  = ~ev_clr & (btn_run | (cmd_valid & (cmd_data == CH_RUN)));
  assign ev_mode = ~ev_clr & ~ev_run & (btn_mode | (cmd_valid & (cmd_data == CH_MODE)));
  assign ev_byte = cmd_valid & ~ev_clr & ~ev_run & ~ev_mode;
  assign tick    = run_q & (presc_q == PRESC_LAST);

`ifdef COUNTER_LOAD_EN
  localparam logic [7:0] CH_LOAD = 8'h6C;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_ESC  = 8'h1B;

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W+3:0] acc_ext, acc_mac;
  logic             is_digit;

  assign is_digit = (cmd_data >= 8'h30) && (cmd_data <= 8'h39);
  assign acc_ext  = {4'b0000, acc_q};
  // acc*10 + digit as shift-add; headroom of 4 bits covers the worst case before saturation
  assign acc_mac  = (acc_ext << 3) + (acc_ext << 1) + {{CNT_W{1'b0}}, cmd_data[3:0]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    commit  = 1'b0;
    if (ev_clr) begin
      state_d = S_IDLE;
    end else if (ev_byte) begin
      case (state_q)
        S_IDLE: begin
          if (cmd_data == CH_LOAD) begin
            state_d = S_LOAD;
            acc_d   = '0;
          end
        end
        S_LOAD: begin
          if (is_digit) begin
            acc_d = (acc_mac > {4'b0000, CNT_TOP}) ? CNT_TOP : acc_mac[CNT_W-1:0];
          end else if (cmd_data == CH_CR) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else if (cmd_data == CH_ESC) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  assign load_val  = acc_q;
  assign o_loading = (state_q == S_LOAD);
`else
  assign commit    = 1'b0;
  assign load_val  = '0;
  assign o_loading = 1'b0;
`endif

  // Count priority: clear > load commit > tick; a stop swallows a coincident tick.
  always_comb begin
    cnt_d   = cnt_q;
    run_d   = run_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (ev_clr) begin
      cnt_d   = '0;
      presc_d = '0;
    end else if (ev_run) begin
      run_d   = ~run_q;
      presc_d = '0;
    end else begin
      if (run_q) presc_d = tick ? '0 : presc_q + PW'(1);
      if (ev_mode) mode_d = ~mode_q;
      if (commit) begin
        cnt_d = load_val;
      end else if (tick) begin
        if (mode_q) begin
          if (cnt_q == '0) begin
            cnt_d  = CNT_TOP;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          if (cnt_q == CNT_TOP) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
    end
  end

  assign o_count   = cnt_q;
  assign o_running = run_q;
  assign o_mode    = mode_q;
  assign o_wrap    = wrap_q;
endmodule

// File: tb/tb_mod_counter_unit.sv
// Bench for mod_counter_unit: two configurations share one stimulus stream and are checked
// every cycle against an arithmetic reference model, plus hand-computed directed points.
module tb_mod_counter_unit;
`ifdef COUNTER_LOAD_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_clear, btn_run, btn_mode, cmd_valid;
  logic [7:0] cmd_data;

  logic [13:0] o_count0;
  logic [2:0]  o_count1;
  logic        o_running0, o_mode0, o_wrap0, o_loading0;
  logic        o_running1, o_mode1, o_wrap1, o_loading1;

  always #5 clk = ~clk;

  mod_counter_unit #(.CNT_MAX(9999), .TICK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .btn_clear(btn_clear), .btn_run(btn_run), .btn_mode(btn_mode),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .o_count(o_count0), .o_running(o_running0),
    .o_mode(o_mode0), .o_wrap(o_wrap0), .o_loading(o_loading0));

  mod_counter_unit #(.CNT_MAX(5), .TICK_DIV(3)) u1 (
    .clk(clk), .rst(rst), .btn_clear(btn_clear), .btn_run(btn_run), .btn_mode(btn_mode),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .o_count(o_count1), .o_running(o_running1),
    .o_mode(o_mode1), .o_wrap(o_wrap1), .o_loading(o_loading1));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 -> u0, index 1 -> u1
  int MAXV[2] = '{9999, 5};
  int DIV[2]  = '{4, 3};
  int m_cnt[2], m_presc[2], m_acc[2];
  bit m_run[2], m_mode[2], m_wrap[2], m_load[2];

  task automatic model_step(input int i);
    int c, p, a, n;
    bit run, md, ld, w, tick, commit;
    bit e_clr, e_run, e_mode, e_byte;
    c = m_cnt[i]; p = m_presc[i]; a = m_acc[i];
    run = m_run[i]; md = m_mode[i]; ld = m_load[i];
    w = 1'b0; commit = 1'b0;
    n = MAXV[i] + 1;
    e_clr  = btn_clear || (cmd_valid && cmd_data == 8'h63);
    e_run  = !e_clr && (btn_run || (cmd_valid && cmd_data == 8'h72));
    e_mode = !e_clr && !e_run && (btn_mode || (cmd_valid && cmd_data == 8'h6D));
    e_byte = cmd_valid && !e_clr && !e_run && !e_mode;
    tick   = run && (p == DIV[i] - 1);
    if (e_clr) begin
      c = 0; p = 0; ld = 1'b0;
    end else if (e_run) begin
      run = !run; p = 0;
    end else begin
      if (run) p = (p + 1) % DIV[i];
      if (e_byte && LE) begin
        if (!ld && cmd_data == 8'h6C) begin
          ld = 1'b1; a = 0;
        end else if (ld && cmd_data >= 8'h30 && cmd_data <= 8'h39) begin
          a = a * 10 + (int'(cmd_data) - 48);
          if (a > MAXV[i]) a = MAXV[i];
        end else if (ld && cmd_data == 8'h0D) begin
          commit = 1'b1; ld = 1'b0;
        end else if (ld && cmd_data == 8'h1B) begin
          ld = 1'b0;
        end
      end
      if (commit) c = a;
      else if (tick) begin
        w = md ? (c == 0) : (c == MAXV[i]);
        c = md ? (c + MAXV[i]) % n : (c + 1) % n;
      end
      if (e_mode) md = !md;
    end
    m_cnt[i] <= c; m_presc[i] <= p; m_acc[i] <= a;
    m_run[i] <= run; m_mode[i] <= md; m_load[i] <= ld; m_wrap[i] <= w;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0; m_presc[i] <= 0; m_acc[i] <= 0;
        m_run[i] <= 1'b0; m_mode[i] <= 1'b0; m_wrap[i] <= 1'b0; m_load[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Single compare process, sampled on the inactive edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("u0.count",   int'(o_count0),   m_cnt[0]);
      check("u0.running", int'(o_running0), int'(m_run[0]));
      check("u0.mode",    int'(o_mode0),    int'(m_mode[0]));
      check("u0.wrap",    int'(o_wrap0),    int'(m_wrap[0]));
      check("u0.loading", int'(o_loading0), int'(m_load[0]));
      check("u1.count",   int'(o_count1),   m_cnt[1]);
      check("u1.running", int'(o_running1), int'(m_run[1]));
      check("u1.mode",    int'(o_mode1),    int'(m_mode[1]));
      check("u1.wrap",    int'(o_wrap1),    int'(m_wrap[1]));
      check("u1.loading", int'(o_loading1), int'(m_load[1]));
    end
  end

  task automatic tx(input logic [7:0] b);
    cmd_data = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
  endtask

  initial begin
    int r, k;
    rst = 1'b1; btn_clear = 1'b0; btn_run = 1'b0; btn_mode = 1'b0;
    cmd_valid = 1'b0; cmd_data = 8'h00;
    idle(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst.count", int'(o_count0), 0);
    check("rst.running", int'(o_running0), 0);
    check("rst.mode", int'(o_mode0), 0);
    check("rst.wrap", int'(o_wrap0), 0);
    check("rst.loading", int'(o_loading0), 0);

    // 'r' then one step per 4 cycles on u0; u1 (max 5, div 3) wraps after 6 ticks
    tx(8'h72);
    idle(4);
    check("run.step1", int'(o_count0), 1);
    check("model.step1", m_cnt[0], 1);
    idle(8);
    check("run.step3", int'(o_count0), 3);
    check("run.running", int'(o_running0), 1);
    idle(5);
    check("u1.pre_wrap", int'(o_count1), 5);
    check("u1.pre_wrap_w", int'(o_wrap1), 0);
    idle(1);
    check("u1.wrap_cnt", int'(o_count1), 0);
    check("u1.wrap_pulse", int'(o_wrap1), 1);
    check("u0.step4", int'(o_count0), 4);
    tx(8'h72);

    // down mode from 0 wraps to CNT_MAX
    pulse_clear();
    tx(8'h6D);
    tx(8'h72);
    idle(3);
    check("dn.before", int'(o_count0), 0);
    idle(1);
    check("dn.wrap_cnt", int'(o_count0), 9999);
    check("dn.wrap_pulse", int'(o_wrap0), 1);
    idle(1);
    check("dn.wrap_1cyc", int'(o_wrap0), 0);

    // clear beats a same-cycle run toggle
    btn_clear = 1'b1; btn_run = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0; btn_run = 1'b0;
    check("clr_run.count", int'(o_count0), 0);
    check("clr_run.running", int'(o_running0), 1);

    // clear coincident with a tick: no wrap
    idle(3);
    pulse_clear();
    check("clr_tick.count", int'(o_count0), 0);
    check("clr_tick.wrap", int'(o_wrap0), 0);

    // stop, up mode, zero
    tx(8'h72);
    btn_mode = 1'b1; @(negedge clk); btn_mode = 1'b0;
    pulse_clear();

    tx(8'h6C);
    check("ld.enter", int'(o_loading0), int'(LE));
    tx(8'h31); tx(8'h32); tx(8'h33);
    check("ld.digits", int'(o_loading0), int'(LE));
    tx(8'h0D);
    check("ld.commit_cnt", int'(o_count0), LE ? 123 : 0);
    check("ld.commit_exit", int'(o_loading0), 0);
    tx(8'h6C);
    repeat (5) tx(8'h39);
    tx(8'h0D);
    check("ld.saturate", int'(o_count0), LE ? 9999 : 0);
    tx(8'h6C); tx(8'h35); tx(8'h1B);
    check("ld.abort_cnt", int'(o_count0), LE ? 9999 : 0);
    check("ld.abort_exit", int'(o_loading0), 0);

    // commit coincident with a tick: committed value wins
    tx(8'h72);
    tx(8'h6C);
    tx(8'h37);
    idle(1);
    tx(8'h0D);
    check("ld_tick.count", int'(o_count0), LE ? 7 : 1);
    check("ld_tick.wrap", int'(o_wrap0), 0);

    // reset mid-load
    tx(8'h72);
    tx(8'h6C); tx(8'h37); tx(8'h37); tx(8'h0D);
    check("ld.77", int'(o_count0), LE ? 77 : 1);
    tx(8'h6C); tx(8'h33);
    #2 rst = 1'b1;
    #1;
    check("arst.count", int'(o_count0), 0);
    check("arst.running", int'(o_running0), 0);
    check("arst.mode", int'(o_mode0), 0);
    check("arst.wrap", int'(o_wrap0), 0);
    check("arst.loading", int'(o_loading0), 0);
    check("arst.u1count", int'(o_count1), 0);
    @(negedge clk);
    rst = 1'b0;
    tx(8'h0D);
    check("arst.cr_count", int'(o_count0), 0);
    check("arst.cr_loading", int'(o_loading0), 0);

    // randomized traffic
    for (int cyc = 0; cyc < 6000; cyc++) begin
      r = $urandom_range(0, 199);
      btn_clear = (r == 0);
      btn_run   = (r >= 1 && r <= 3);
      btn_mode  = (r == 4 || r == 5);
      cmd_valid = ($urandom_range(0, 99) < 30);
      k = $urandom_range(0, 39);
      if (k == 0)       cmd_data = 8'h63;
      else if (k < 3)   cmd_data = 8'h72;
      else if (k < 5)   cmd_data = 8'h6D;
      else if (k < 10)  cmd_data = 8'h6C;
      else if (k < 26)  cmd_data = 8'(8'h30 + $urandom_range(0, 9));
      else if (k < 31)  cmd_data = 8'h0D;
      else if (k < 34)  cmd_data = 8'h1B;
      else              cmd_data = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 1999) == 0);
      @(negedge clk);
    end
    rst = 1'b0; btn_clear = 1'b0; btn_run = 1'b0; btn_mode = 1'b0; cmd_valid = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mod_counter_unit.md
# mod_counter_unit

Parametrised run/stop, up/down modulo counter with an internal tick prescaler and merged button/UART command decoding. It replaces the fixed 0–9999 counter datapath and its controller. It sits between the debounced buttons / UART RX pop interface and the FND controller. It adds a configurable modulus and rate, a wrap strobe, and optional decimal preload over UART.

## Interface
- CNT_MAX, 9999: highest count value; counter runs 0..CNT_MAX. Must be ≥1.
- TICK_DIV, 10_000_000: clk cycles per count step. Must be ≥2.
- CNT_W, $clog2(CNT_MAX+1): derived count width; not to be overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- btn_clear  in  1  debounced single-cycle pulse: clear
- btn_run  in  1  debounced single-cycle pulse: toggle run/stop
- btn_mode  in  1  debounced single-cycle pulse: toggle up/down
- cmd_data  in  8  UART RX byte, qualified by cmd_valid
- cmd_valid  in  1  single-cycle strobe, cmd_data valid
- o_count  out  CNT_W  current count
- o_running  out  1  1 = counting
- o_mode  out  1  0 = up, 1 = down
- o_wrap  out  1  one-cycle pulse on modulo wrap
- o_loading  out  1  1 = in LOAD state (always 0 without load feature)

## Operation
- Command decode, one event per cycle, priority high→low:
  - clear: btn_clear, or cmd 0x63 'c'
  - run toggle: btn_run, or 0x72 'r'
  - mode toggle: btn_mode, or 0x6D 'm'
  - load bytes
- A lower-priority event in the same cycle is dropped.
- clear: o_count←0, prescaler←0, LOAD aborted. o_running and o_mode are unchanged.
- run toggle: flips o_running. Prescaler←0 on every toggle.
- Prescaler counts 0..TICK_DIV-1 only while running. An internal tick asserts for one cycle as the prescaler rolls over.
- On tick, up mode: CNT_MAX→0 with o_wrap; otherwise +1.
- On tick, down mode: 0→CNT_MAX with o_wrap; otherwise −1.
- Load FSM, two states: IDLE and LOAD.
  - IDLE→LOAD on 'l' (0x6C). Accumulator←0.
  - In LOAD, digit '0'–'9' sets acc←acc*10+digit, saturating at CNT_MAX. Intermediate width is CNT_W+4.
  - 0x0D commits: o_count←acc, then LOAD→IDLE.
  - 0x1B aborts: LOAD→IDLE, count untouched.
  - Other bytes are ignored. 'c', 'r' and 'm' still execute while in LOAD. A clear also exits LOAD.
  - Counting continues during LOAD.
- Same-cycle conflicts on o_count: clear > load commit > tick.

## Timing
- Reset values: o_count=0, o_running=0, o_mode=0, o_wrap=0, o_loading=0. Prescaler=0, FSM=IDLE, acc=0.
- Every command takes effect on the clk edge after the cycle in which its strobe is high. All outputs are registered.
- First tick comes TICK_DIV cycles after the run-start edge, then one every TICK_DIV cycles. o_count changes on the edge following the tick.
- o_wrap is high in the same cycle that o_count shows the wrapped value, for exactly one cycle.
- A stop issued in the same cycle as a tick takes priority, so that tick's count update is suppressed.
- Reset asserted mid-count or mid-load returns everything to the reset values immediately.

## Configuration
- COUNTER_LOAD_EN defined: the LOAD FSM, accumulator and o_loading logic are compiled in.
- COUNTER_LOAD_EN undefined: bytes 0x6C, digits, 0x0D and 0x1B are ignored. o_loading is tied to 0. Everything else is identical.

## Test plan
All scenarios use CNT_MAX=9999 and TICK_DIV=4 unless stated.
- Reset, then 'r', then 12 cycles → o_running=1, o_count steps 0→1→2→3, one step per 4 cycles.
- Down mode at 0, run, one tick → o_count=9999 with a one-cycle o_wrap. Repeat with CNT_MAX=5 in up mode: 5→0 with o_wrap.
- Bytes 'l','1','2','3',0x0D → o_loading=1 from 'l' to the commit, then o_count=123. 'l','9','9','9','9','9',0x0D → 9999 (saturated). 'l','5',0x1B → count unchanged.
- btn_clear and btn_run in the same cycle while running at 42 → o_count=0, o_running stays 1. Clear coincident with a tick → 0, no wrap.
- Load commit coincident with a tick → committed value wins.
- Reset asserted mid-LOAD with count 77 → all outputs 0 immediately. The next 0x0D has no effect.
- With COUNTER_LOAD_EN undefined, 'l','5',0x0D → o_count unchanged, o_loading=0.
